// File: rtl/host_sequencer.sv
// host_sequencer
//   Front-end controller wrapped around the processor core. A session loads
//   IMG_BYTES host bytes into data memory (addresses 0..IMG_BYTES-1), lets
//   the processor run until end_process, then streams RES_BYTES bytes
//   starting at RES_BASE back to the host.
//
// Optional feature: define SEQ_TIMEOUT_EN to enable the run watchdog
//   (TIMEOUT_CYCLES). Without it, timeout is tied to 0 and RUN waits forever.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   start             begin a session (sampled only in IDLE or DONE)
//   rx_data/valid/rdy host -> sequencer byte stream
//   status            processor mode: 01 run, 10 write DM, 11 read DM (dm_en low)
//   data_in           byte written to DM
//   data_addr_in      DM address for load and readback
//   end_process       processor finished its program
//   dm_out            DM read data, valid RD_LAT edges after the address
//   tx_data/valid/rdy sequencer -> host result byte stream
//   busy, done        session in progress / session finished (level)
//   timeout           watchdog aborted the last run
//   state_dbg         current FSM state encoding, for observation only
//
// Handshakes: a byte moves on a rising edge where valid and ready are both
//   high. The source holds data stable while valid is high and ready is low;
//   valid never depends combinationally on ready. All outputs are registers.

module host_sequencer #(
   parameter logic [15:0] IMG_BYTES      = 16'd256,
   parameter logic [15:0] RES_BASE       = 16'd0,
   parameter logic [15:0] RES_BYTES      = 16'd256,
   parameter int unsigned RD_LAT         = 3,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [1:0]  status,
   output logic [7:0]  data_in,
   output logic [15:0] data_addr_in,
   input  logic        end_process,
   input  logic [7:0]  dm_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FLUSH = 3'd2,
      S_RUN   = 3'd3,
      S_RADDR = 3'd4,
      S_RWAIT = 3'd5,
      S_SEND  = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_WRITE = 2'b10;
   localparam logic [1:0] ST_IDLE  = 2'b11;

   // Last value of the wait counter: the RD_LAT-th edge after the address edge.
   localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

   state_t      state, state_nxt;
   logic [1:0]  status_nxt;
   logic [7:0]  data_in_nxt;
   logic [15:0] addr_nxt;
   logic        rx_ready_nxt;
   logic [7:0]  tx_data_nxt;
   logic        tx_valid_nxt;
   logic        busy_nxt;
   logic        done_nxt;
   logic        timeout_nxt;
   logic [15:0] load_cnt, load_cnt_nxt;
   logic [15:0] rd_idx, rd_idx_nxt;
   logic [2:0]  lat_cnt, lat_cnt_nxt;

`ifdef SEQ_TIMEOUT_EN
   logic [31:0] to_cnt, to_cnt_nxt;
`else
   // The watchdog limit only matters when the watchdog is built in.
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   assign state_dbg = state;

   always_comb begin
      state_nxt    = state;
      // Default to "read, dm_en low" so a cycle without a handshake never
      // repeats the previous write.
      status_nxt   = ST_IDLE;
      data_in_nxt  = data_in;
      addr_nxt     = data_addr_in;
      rx_ready_nxt = 1'b0;
      tx_data_nxt  = tx_data;
      tx_valid_nxt = tx_valid;
      timeout_nxt  = timeout;
      load_cnt_nxt = load_cnt;
      rd_idx_nxt   = rd_idx;
      lat_cnt_nxt  = lat_cnt;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_nxt   = to_cnt;
`endif

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               timeout_nxt  = 1'b0;
               load_cnt_nxt = 16'd0;
               if (IMG_BYTES == 16'd0) begin
                  state_nxt = S_FLUSH;
               end else begin
                  state_nxt    = S_LOAD;
                  rx_ready_nxt = 1'b1;
               end
            end
         end

         S_LOAD: begin
            rx_ready_nxt = 1'b1;
            if (rx_valid && rx_ready) begin
               status_nxt   = ST_WRITE;
               data_in_nxt  = rx_data;
               addr_nxt     = load_cnt;
               load_cnt_nxt = load_cnt + 16'd1;
               if (load_cnt == IMG_BYTES - 16'd1) begin
                  rx_ready_nxt = 1'b0;
                  state_nxt    = S_FLUSH;
               end
            end
         end

         // One idle-status cycle so the processor commits the last write
         // before it is switched to run mode.
         S_FLUSH: begin
            state_nxt = S_RUN;
`ifdef SEQ_TIMEOUT_EN
            to_cnt_nxt = 32'd0;
`endif
         end

         S_RUN: begin
            if (end_process) begin
               rd_idx_nxt = 16'd0;
               state_nxt  = (RES_BYTES == 16'd0) ? S_DONE : S_RADDR;
            end else begin
`ifdef SEQ_TIMEOUT_EN
               if (to_cnt == TIMEOUT_CYCLES - 32'd1) begin
                  timeout_nxt = 1'b1;
                  state_nxt   = S_DONE;
               end else begin
                  status_nxt = ST_RUN;
                  to_cnt_nxt = to_cnt + 32'd1;
               end
`else
               status_nxt = ST_RUN;
`endif
            end
         end

         S_RADDR: begin
            addr_nxt    = RES_BASE + rd_idx;
            lat_cnt_nxt = 3'd0;
            state_nxt   = S_RWAIT;
         end

         S_RWAIT: begin
            if (lat_cnt == LAT_LAST) begin
               tx_data_nxt  = dm_out;
               tx_valid_nxt = 1'b1;
               state_nxt    = S_SEND;
            end else begin
               lat_cnt_nxt = lat_cnt + 3'd1;
            end
         end

         S_SEND: begin
            if (tx_ready) begin
               tx_valid_nxt = 1'b0;
               rd_idx_nxt   = rd_idx + 16'd1;
               state_nxt    = (rd_idx + 16'd1 == RES_BYTES) ? S_DONE : S_RADDR;
            end
         end

         default: state_nxt = S_IDLE;
      endcase

      busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done_nxt = (state_nxt == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         status       <= ST_IDLE;
         data_in      <= 8'd0;
         data_addr_in <= 16'd0;
         rx_ready     <= 1'b0;
         tx_data      <= 8'd0;
         tx_valid     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout      <= 1'b0;
         load_cnt     <= 16'd0;
         rd_idx       <= 16'd0;
         lat_cnt      <= 3'd0;
`ifdef SEQ_TIMEOUT_EN
         to_cnt       <= 32'd0;
`endif
      end else begin
         state        <= state_nxt;
         status       <= status_nxt;
         data_in      <= data_in_nxt;
         data_addr_in <= addr_nxt;
         rx_ready     <= rx_ready_nxt;
         tx_data      <= tx_data_nxt;
         tx_valid     <= tx_valid_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         timeout      <= timeout_nxt;
         load_cnt     <= load_cnt_nxt;
         rd_idx       <= rd_idx_nxt;
         lat_cnt      <= lat_cnt_nxt;
`ifdef SEQ_TIMEOUT_EN
         to_cnt       <= to_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_host_sequencer.sv
// Testbench for host_sequencer with a small processor/data-memory model.
// The model writes DM on status==10 and returns dm[addr] through a two-stage
// read pipeline (RD_LAT=3). Result addresses 0x10..0x13 read back as image
// byte (addr-0x10) XOR 0xA5, standing in for the processor's program.

module tb_host_sequencer;

   localparam logic [15:0] IMG       = 16'd4;
   localparam logic [15:0] RES_BASE  = 16'h0010;
   localparam logic [15:0] RES       = 16'd3;
   localparam int          RD_LAT    = 3;
   localparam logic [31:0] TO_CYCLES = 32'd100;

   logic        clk, rst, start;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready;
   logic [1:0]  status;
   logic [7:0]  data_in;
   logic [15:0] data_addr_in;
   logic        end_process;
   logic [7:0]  dm_out;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic        busy, done, timeout;
   logic [2:0]  state_dbg;

   host_sequencer #(
      .IMG_BYTES(IMG), .RES_BASE(RES_BASE), .RES_BYTES(RES),
      .RD_LAT(RD_LAT), .TIMEOUT_CYCLES(TO_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .status(status), .data_in(data_in), .data_addr_in(data_addr_in),
      .end_process(end_process), .dm_out(dm_out),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .timeout(timeout), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- processor / DM model ----------------
   logic [7:0] dm [256];
   logic [7:0] rd_p0, rd_p1;

   function automatic logic [7:0] dm_read(input logic [15:0] a);
      logic [7:0] off;
      if (a >= 16'h0010 && a < 16'h0014) begin
         off = a[7:0] - 8'h10;
         return dm[off] ^ 8'hA5;
      end
      return dm[a[7:0]];
   endfunction

   always @(posedge clk) begin
      if (status == 2'b10) dm[data_addr_in[7:0]] <= data_in;
      rd_p0 <= dm_read(data_addr_in);
      rd_p1 <= rd_p0;
   end
   assign dm_out = rd_p1;

   // ---------------- scoreboard ----------------
   logic [23:0] wr_exp_q[$];
   logic [7:0]  tx_exp_q[$];
   logic [7:0]  img [4];
   int checks_total  = 0;
   int checks_passed = 0;
   int checks_failed = 0;
   int cyc = 0;
   int last_hs = 0;
   int hs_gap = 0;
   int hs_count = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else begin
         checks_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: tx handshake check before the edge, write check after it.
   task automatic step();
      logic [31:0] exp;
      if (tx_valid) begin
         if (tx_exp_q.size() != 0) exp = {24'd0, tx_exp_q[0]};
         else exp = 'x;
         check(tx_ready ? "tx_hs_data" : "tx_hold_data", {24'd0, tx_data}, exp);
         if (tx_ready) begin
            if (tx_exp_q.size() != 0) void'(tx_exp_q.pop_front());
            hs_count++;
            hs_gap  = cyc - last_hs;
            last_hs = cyc;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (status == 2'b10) begin
         if (wr_exp_q.size() != 0) exp = {8'd0, wr_exp_q.pop_front()};
         else exp = 'x;
         check("dm_write", {8'd0, data_addr_in, data_in}, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic check_reset(input string tag);
      check({tag, "_status"}, {30'd0, status}, 32'd3);
      check({tag, "_data_in"}, {24'd0, data_in}, 32'd0);
      check({tag, "_addr"}, {16'd0, data_addr_in}, 32'd0);
      check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
      check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
      check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
      check({tag, "_state"}, {29'd0, state_dbg}, 32'd0);
   endtask

   task automatic new_img();
      for (int i = 0; i < 4; i++) img[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_rx_ready", {31'd0, rx_ready}, 32'd1);
      check("start_done", {31'd0, done}, 32'd0);
      check("start_timeout", {31'd0, timeout}, 32'd0);
   endtask

   task automatic load_img(input bit gapped);
      for (int i = 0; i < int'(IMG); i++) begin
         rx_valid = 1'b1;
         rx_data  = img[i];
         wr_exp_q.push_back({16'(i), img[i]});
         step();
         check("load_status", {30'd0, status}, 32'd2);
         check("load_rx_ready", {31'd0, rx_ready}, (i == int'(IMG) - 1) ? 32'd0 : 32'd1);
         if (gapped && i < int'(IMG) - 1) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom_range(0, 255));
            step();
            check("gap_status", {30'd0, status}, 32'd3);
         end
      end
      rx_valid = 1'b0;
      check("load_all_written", wr_exp_q.size(), 32'd0);
   endtask

   task automatic push_results();
      for (int i = 0; i < int'(RES); i++) tx_exp_q.push_back(img[i] ^ 8'hA5);
   endtask

   task automatic readback(input bit rnd);
      for (int k = 0; k < 300; k++) begin
         tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         if (done) break;
      end
      tx_ready = 1'b0;
      check("rb_done", {31'd0, done}, 32'd1);
      check("rb_busy", {31'd0, busy}, 32'd0);
      check("rb_status", {30'd0, status}, 32'd3);
      check("rb_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rb_all_sent", tx_exp_q.size(), 32'd0);
   endtask

   task automatic full_session(input bit gapped, input bit rnd);
      new_img();
      do_start();
      load_img(gapped);
      step();
      check("fs_flush_status", {30'd0, status}, 32'd3);
      step();
      check("fs_run_status", {30'd0, status}, 32'd1);
      tx_ready    = 1'b0;
      end_process = 1'b1;
      push_results();
      step();
      end_process = 1'b0;
      check("fs_end_status", {30'd0, status}, 32'd3);
      readback(rnd);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int n;
      int tx_seen;
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
      end_process = 1'b0; tx_ready = 1'b0;

      // Reset then idle
      step(); step();
      check_reset("reset");
      rst = 1'b0;
      step();
      check("idle_status", {30'd0, status}, 32'd3);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Load burst 11,22,33,44 then flush and run
      img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
      do_start();
      load_img(1'b0);
      step();
      check("burst_flush_status", {30'd0, status}, 32'd3);
      check("burst_flush_busy", {31'd0, busy}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         step();
         check("burst_run_status", {30'd0, status}, 32'd1);
      end

      // Readback with 5 cycles of backpressure on the first byte
      tx_ready    = 1'b0;
      end_process = 1'b1;
      push_results();
      lat = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         lat++;
         end_process = 1'b0;
         if (tx_valid) break;
      end
      check("first_tx_latency", lat, RD_LAT + 2);
      repeat (5) begin
         step();
         check("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
      end
      hs_count = 0;
      readback(1'b0);
      check("rb_handshakes", hs_count, 32'd3);
      check("rb_byte_period", hs_gap, RD_LAT + 2);

      // Gapped load, end_process already high on the first RUN cycle
      new_img();
      do_start();
      load_img(1'b1);
      step();
      check("gap_flush_status", {30'd0, status}, 32'd3);
      end_process = 1'b1;
      push_results();
      step();
      end_process = 1'b0;
      check("imm_end_status", {30'd0, status}, 32'd3);
      check("imm_end_state", {29'd0, state_dbg}, 32'd4);
      readback(1'b1);

      // Reset in RUN, then a full session
      new_img();
      do_start();
      load_img(1'b0);
      step(); step(); step();
      check("pre_rst_run_status", {30'd0, status}, 32'd1);
      rst = 1'b1;
      step();
      check_reset("run_rst");
      rst = 1'b0;
      full_session(1'b0, 1'b0);

      // Reset in SEND, then a full session
      new_img();
      do_start();
      load_img(1'b0);
      step(); step();
      tx_ready    = 1'b0;
      end_process = 1'b1;
      push_results();
      step();
      end_process = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (tx_valid) break;
         step();
      end
      check("pre_rst_tx_valid", {31'd0, tx_valid}, 32'd1);
      step();
      rst = 1'b1;
      step();
      check_reset("send_rst");
      tx_exp_q.delete();
      rst = 1'b0;
      full_session(1'b1, 1'b1);

`ifdef SEQ_TIMEOUT_EN
      // Watchdog: end_process never rises
      new_img();
      do_start();
      load_img(1'b0);
      step();
      n = 0;
      tx_seen = 0;
      for (int k = 0; k < 400; k++) begin
         step();
         n++;
         if (tx_valid) tx_seen++;
         if (done) break;
      end
      check("to_run_cycles", n, TO_CYCLES);
      check("to_timeout", {31'd0, timeout}, 32'd1);
      check("to_done", {31'd0, done}, 32'd1);
      check("to_status", {30'd0, status}, 32'd3);
      check("to_no_tx", tx_seen, 32'd0);
      full_session(1'b0, 1'b0);
`else
      // Without the watchdog RUN waits well past TO_CYCLES
      new_img();
      do_start();
      load_img(1'b0);
      step();
      n = 0;
      tx_seen = 0;
      for (int k = 0; k < 150; k++) begin
         step();
         n++;
         if (timeout || done || tx_valid) tx_seen++;
      end
      check("nowd_events", tx_seen, 32'd0);
      check("nowd_status", {30'd0, status}, 32'd1);
      check("nowd_busy", {31'd0, busy}, 32'd1);
      check("nowd_cycles", n, 32'd150);
      tx_ready    = 1'b0;
      end_process = 1'b1;
      push_results();
      step();
      end_process = 1'b0;
      readback(1'b0);
`endif

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
